rw_mode_scheduler: RTL

Channel-level read/write mode scheduler, directly upstream of the DQ turnaround timer. It decides when the channel flips between read and write mode from queue occupancy watermarks, minimum-burst and read-starvation rules. It drives `channelMode` and `rankChanged` into the turnaround timer, and gates per-type CAS grants to the ChannelController using the returned `DQTurnaroundFree`.

---
 rtl/mc_sched_pkg.sv | 18 +
 rtl/sat_counter.sv | 30 +++
 rtl/rw_mode_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mc_sched_pkg.sv
// Shared types and width helpers for the channel read/write scheduler.
// Holds the channel mode encoding plus rank/count width functions.
package mc_sched_pkg;

    typedef enum logic {
        MODE_RD = 1'b0,
        MODE_WR = 1'b1
    } chan_mode_e;

    function automatic int rank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports: clk, rst (async high), inc, clr; sat high while count == LIMIT.
module sat_counter #(
    parameter int WIDTH = 3,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    assign sat = (count == LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rw_mode_scheduler.sv
// Channel read/write mode scheduler: picks READ/WRITE from queue watermarks,
// burst and starvation rules; gates CAS grants; flags ungranted CAS.
// Ports: clk, rst, rdQCount, wrQCount, rdHeadRank, casIssue, casIsWrite,
//        casRank, DQTurnaroundFree -> channelMode, rankChanged, rdGrant,
//        wrGrant, protoErr.
module rw_mode_scheduler
    import mc_sched_pkg::*;
#(
    parameter int RQ_DEPTH        = 32,
    parameter int WQ_DEPTH        = 32,
    parameter int WR_HIGH_WM      = 24,
    parameter int WR_LOW_WM       = 8,
    parameter int MIN_BURST       = 4,
    parameter int RD_STARVE_LIMIT = 64,
    parameter int NUM_RANK        = 2,
    localparam int RQ_CNT_W       = cnt_w(RQ_DEPTH),
    localparam int WQ_CNT_W       = cnt_w(WQ_DEPTH),
    localparam int RANK_W         = rank_w(NUM_RANK)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RQ_CNT_W-1:0] rdQCount,
    input  logic [WQ_CNT_W-1:0] wrQCount,
    input  logic [RANK_W-1:0]   rdHeadRank,
    input  logic                casIssue,
    input  logic                casIsWrite,
    input  logic [RANK_W-1:0]   casRank,
    input  logic                DQTurnaroundFree,
    output logic                channelMode,
    output logic                rankChanged,
    output logic                rdGrant,
    output logic                wrGrant,
    output logic                protoErr
);

    localparam int BURST_W  = cnt_w(MIN_BURST);
    localparam int STARVE_W = cnt_w(RD_STARVE_LIMIT);

    localparam logic [WQ_CNT_W-1:0] WR_HI = WQ_CNT_W'(WR_HIGH_WM);
    localparam logic [WQ_CNT_W-1:0] WR_LO = WQ_CNT_W'(WR_LOW_WM);

    chan_mode_e        state;
    logic [RANK_W-1:0] last_wr_rank;
    logic              sw_req;
    logic              burst_full;
    logic              starve_full;
    logic              rd_empty;
    logic              wr_empty;
    logic              wr_high;
    logic              wr_low;
    logic              in_wr;

    assign rd_empty = (rdQCount == '0);
    assign wr_empty = (wrQCount == '0);
    assign wr_high  = (wrQCount >= WR_HI);
    assign wr_low   = (wrQCount <= WR_LO);
    assign in_wr    = (state == MODE_WR);

    // Idle channel (both queues empty) never flips, even if starvation
    // saturated before the reads drained.
    always_comb begin
        sw_req = 1'b0;
        unique case (state)
            MODE_RD: begin
                sw_req = (wr_high && (burst_full || rd_empty))
                       || (rd_empty && !wr_empty);
            end
            MODE_WR: begin
                sw_req = (wr_empty && !rd_empty)
                       || (wr_low && burst_full && !rd_empty)
                       || (starve_full && burst_full);
            end
            default: sw_req = 1'b0;
        endcase
        if (rd_empty && wr_empty) begin
            sw_req = 1'b0;
        end
    end

    sat_counter #(
        .WIDTH(BURST_W),
        .LIMIT(MIN_BURST)
    ) u_burst (
        .clk(clk),
        .rst(rst),
        .inc(casIssue),
        .clr(sw_req),
        .sat(burst_full)
    );

    sat_counter #(
        .WIDTH(STARVE_W),
        .LIMIT(RD_STARVE_LIMIT)
    ) u_starve (
        .clk(clk),
        .rst(rst),
        .inc(in_wr && !rd_empty),
        .clr(!in_wr),
        .sat(starve_full)
    );

    assign channelMode = in_wr;

    assign rdGrant = !in_wr && DQTurnaroundFree && !rd_empty && !sw_req;
    assign wrGrant = in_wr && DQTurnaroundFree && !wr_empty && !sw_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= MODE_RD;
            rankChanged  <= 1'b0;
            protoErr     <= 1'b0;
            last_wr_rank <= '0;
        end else begin
            if (casIssue && (casIsWrite ? !wrGrant : !rdGrant)) begin
                protoErr <= 1'b1;
            end
            if (casIssue && casIsWrite) begin
                last_wr_rank <= casRank;
            end
            // Compare against the rank of the last completed write, not a
            // write landing in the same decision cycle.
            if (sw_req) begin
                unique case (state)
                    MODE_WR: begin
                        state       <= MODE_RD;
                        rankChanged <= (rdHeadRank != last_wr_rank);
                    end
                    MODE_RD: begin
                        state       <= MODE_WR;
                        rankChanged <= 1'b0;
                    end
                    default: begin
                        state       <= MODE_RD;
                        rankChanged <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
